// File: rtl/mem_arb.sv
// mem_arb: arbitrates a single-port unified memory between instruction fetch
// (IF) and the load/store path (DM). DM has fixed priority, but IF is forced
// through after STARVE_MAX consecutive DM grants that it lost. Only one read can
// be outstanding. The memory read latency is fixed. Stale fetch responses are
// dropped when fetch is redirected.
//
// Handshake: a requester holds req and its payload stable until it sees gnt.
// The gnt is combinational in the same cycle, so the payload is driven onto
// o_mem_* in that cycle. A read's data comes back on the owner's rvld exactly
// MEM_LAT cycles after its grant. There is no backpressure on rvld.
module mem_arb #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  input  logic                i_if_flush,
  output logic                o_if_gnt,
  output logic                o_if_rvld,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_dm_req,
  input  logic                i_dm_wen,
  input  logic [ADDR_W-1:0]   i_dm_addr,
  input  logic [DATA_W-1:0]   i_dm_wdata,
  input  logic [DATA_W/8-1:0] i_dm_mask,
  output logic                o_dm_gnt,
  output logic                o_dm_rvld,
  output logic [DATA_W-1:0]   o_dm_rdata,
  output logic                o_mem_req,
  output logic                o_mem_wen,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_mask,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_busy
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_if_q, owner_if_d;
  logic              drop_q, drop_d;
  logic [SC_W-1:0]   starve_q, starve_d;

  logic resp;
  logic can_grant;
  logic if_pick;
  logic if_gnt;
  logic dm_gnt;
  logic rd_gnt;

  // Grant decision: a slot opens in IDLE or in the response cycle of a read.
  always_comb begin
    resp      = (state_q == ST_WAIT) && (cnt_q == CNT_W'(1));
    can_grant = i_rst_n && ((state_q == ST_IDLE) || resp);
    if_pick   = i_if_req && (!i_dm_req || (starve_q == SC_W'(STARVE_MAX)));
    if_gnt    = can_grant && if_pick;
    dm_gnt    = can_grant && i_dm_req && !if_pick;
    rd_gnt    = if_gnt || (dm_gnt && !i_dm_wen);
  end

  // State register, including read owner, drop flag and starvation counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      owner_if_q <= 1'b0;
      drop_q     <= 1'b0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_if_q <= owner_if_d;
      drop_q     <= drop_d;
      starve_q   <= starve_d;
    end
  end

  // Next state: a new read restarts the countdown even in a response cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_if_d = owner_if_q;
    drop_d     = drop_q;
    if (rd_gnt) begin
      state_d    = ST_WAIT;
      cnt_d      = CNT_W'(MEM_LAT);
      owner_if_d = if_gnt;
      drop_d     = if_gnt && i_if_flush;
    end else if (resp) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      drop_d  = 1'b0;
    end else if (state_q == ST_WAIT) begin
      cnt_d  = cnt_q - CNT_W'(1);
      drop_d = drop_q || (owner_if_q && i_if_flush);
    end

    starve_d = starve_q;
    if (!i_if_req || if_gnt)
      starve_d = '0;
    else if (dm_gnt && (starve_q != SC_W'(STARVE_MAX)))
      starve_d = starve_q + SC_W'(1);
  end

  // Outputs: grants steer the memory port; responses go to the read's owner.
  always_comb begin
    o_if_gnt    = if_gnt;
    o_dm_gnt    = dm_gnt;
    o_mem_req   = if_gnt || dm_gnt;
    o_mem_wen   = dm_gnt && i_dm_wen;
    o_mem_addr  = if_gnt ? i_if_addr : i_dm_addr;
    o_mem_wdata = i_dm_wdata;
    o_mem_mask  = dm_gnt ? i_dm_mask : '0;
    o_if_rvld   = i_rst_n && resp && owner_if_q && !drop_q && !i_if_flush;
    o_dm_rvld   = i_rst_n && resp && !owner_if_q;
    o_if_rdata  = i_mem_rdata;
    o_dm_rdata  = i_mem_rdata;
    o_busy      = i_rst_n && (state_q == ST_WAIT);
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed bench for mem_arb. The u1 instance has MEM_LAT=1 and is
// driven from a vector table. The u2 instance has MEM_LAT=2 and is exercised by
// hand-written multi-cycle sequences. Both instances share the same inputs.
module tb_mem_arb;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        dm_req;
  logic        dm_wen;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_mask;
  logic [31:0] mem_rdata;

  logic        if_gnt1, if_rvld1, dm_gnt1, dm_rvld1, mem_req1, mem_wen1, busy1;
  logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;
  logic [3:0]  mem_mask1;
  logic        if_gnt2, if_rvld2, dm_gnt2, dm_rvld2, mem_req2, mem_wen2, busy2;
  logic [31:0] if_rdata2, dm_rdata2, mem_addr2, mem_wdata2;
  logic [3:0]  mem_mask2;

  int n_vec = 0;
  int n_err = 0;

  mem_arb #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
    .o_if_gnt(if_gnt1), .o_if_rvld(if_rvld1), .o_if_rdata(if_rdata1),
    .i_dm_req(dm_req), .i_dm_wen(dm_wen), .i_dm_addr(dm_addr),
    .i_dm_wdata(dm_wdata), .i_dm_mask(dm_mask),
    .o_dm_gnt(dm_gnt1), .o_dm_rvld(dm_rvld1), .o_dm_rdata(dm_rdata1),
    .o_mem_req(mem_req1), .o_mem_wen(mem_wen1), .o_mem_addr(mem_addr1),
    .o_mem_wdata(mem_wdata1), .o_mem_mask(mem_mask1),
    .i_mem_rdata(mem_rdata), .o_busy(busy1)
  );

  mem_arb #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u2 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
    .o_if_gnt(if_gnt2), .o_if_rvld(if_rvld2), .o_if_rdata(if_rdata2),
    .i_dm_req(dm_req), .i_dm_wen(dm_wen), .i_dm_addr(dm_addr),
    .i_dm_wdata(dm_wdata), .i_dm_mask(dm_mask),
    .o_dm_gnt(dm_gnt2), .o_dm_rvld(dm_rvld2), .o_dm_rdata(dm_rdata2),
    .o_mem_req(mem_req2), .o_mem_wen(mem_wen2), .o_mem_addr(mem_addr2),
    .o_mem_wdata(mem_wdata2), .o_mem_mask(mem_mask2),
    .i_mem_rdata(mem_rdata), .o_busy(busy2)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        rst_n, if_req;
    logic [31:0] if_addr;
    logic        flush, dm_req, dm_wen;
    logic [31:0] dm_addr, wdata;
    logic [3:0]  mask;
    logic [31:0] rdata;
    logic        e_if_gnt, e_dm_gnt, e_if_rvld, e_dm_rvld, e_wen, e_busy;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(string nm, logic r, logic ir, logic [31:0] ia,
                               logic fl, logic dr, logic dw, logic [31:0] da,
                               logic [31:0] wd, logic [3:0] mk, logic [31:0] rd,
                               logic eig, logic edg, logic eir, logic edr,
                               logic ew, logic eb, logic [31:0] ea);
    vec_t v;
    v.nm = nm; v.rst_n = r; v.if_req = ir; v.if_addr = ia; v.flush = fl;
    v.dm_req = dr; v.dm_wen = dw; v.dm_addr = da; v.wdata = wd; v.mask = mk;
    v.rdata = rd; v.e_if_gnt = eig; v.e_dm_gnt = edg; v.e_if_rvld = eir;
    v.e_dm_rvld = edr; v.e_wen = ew; v.e_busy = eb; v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Driver: drive a cycle's inputs on the falling edge, then let outputs settle.
  task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                       input logic fl, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] wd,
                       input logic [3:0] mk, input logic [31:0] rd);
    @(negedge clk);
    rst_n = r; if_req = ir; if_addr = ia; if_flush = fl; dm_req = dr;
    dm_wen = dw; dm_addr = da; dm_wdata = wd; dm_mask = mk; mem_rdata = rd;
    #1;
  endtask

  task automatic chk2(input string nm, input logic eig, input logic edg,
                      input logic eir, input logic edr, input logic eb);
    chk({nm, ".if_gnt"},  {31'd0, if_gnt2},  {31'd0, eig});
    chk({nm, ".dm_gnt"},  {31'd0, dm_gnt2},  {31'd0, edg});
    chk({nm, ".if_rvld"}, {31'd0, if_rvld2}, {31'd0, eir});
    chk({nm, ".dm_rvld"}, {31'd0, dm_rvld2}, {31'd0, edr});
    chk({nm, ".busy"},    {31'd0, busy2},    {31'd0, eb});
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0; dm_req = 1'b0;
    dm_wen = 1'b0; dm_addr = '0; dm_wdata = '0; dm_mask = '0; mem_rdata = '0;

    // Vector table for the MEM_LAT=1 instance.
    //                 name            rst ir ia        fl dr dw da        wdata         mk    rdata          ig dg ir dr w  b  addr
    vecs.push_back(mkv("rst0",         0, 1, 32'h100, 0, 1, 0, 32'h104, 32'h0,        4'h0, 32'h0,         0, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mkv("rst1",         0, 1, 32'h100, 0, 1, 0, 32'h104, 32'h0,        4'h0, 32'h0,         0, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mkv("dm_wr",        1, 1, 32'h300, 0, 1, 1, 32'h200, 32'h12345678, 4'h3, 32'h0,         0, 1, 0, 0, 1, 0, 32'h200));
    vecs.push_back(mkv("if_after_wr",  1, 1, 32'h300, 0, 0, 0, 32'h0,   32'h0,        4'h0, 32'h0,         1, 0, 0, 0, 0, 0, 32'h300));
    vecs.push_back(mkv("if_resp",      1, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,        4'h0, 32'hA5A50001,  0, 0, 1, 0, 0, 1, 32'h0));
    vecs.push_back(mkv("both_rd",      1, 1, 32'h400, 0, 1, 0, 32'h500, 32'h0,        4'h0, 32'h0,         0, 1, 0, 0, 0, 0, 32'h500));
    vecs.push_back(mkv("dm_resp_ifg",  1, 1, 32'h400, 0, 0, 0, 32'h0,   32'h0,        4'h0, 32'h0D0D0D0D,  1, 0, 0, 1, 0, 1, 32'h400));
    vecs.push_back(mkv("if_resp2",     1, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,        4'h0, 32'h1F1F1F1F,  0, 0, 1, 0, 0, 1, 32'h0));
    vecs.push_back(mkv("idle",         1, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,        4'h0, 32'h0,         0, 0, 0, 0, 0, 0, 32'h0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mkv("starve_dm",  1, 1, 32'h600, 0, 1, 1, 32'h700, 32'h11110000 + i, 4'hF, 32'h0,  0, 1, 0, 0, 1, 0, 32'h700));
    vecs.push_back(mkv("starve_if",    1, 1, 32'h600, 0, 1, 1, 32'h700, 32'h22220000, 4'hF, 32'h0,         1, 0, 0, 0, 0, 0, 32'h600));
    vecs.push_back(mkv("after_force",  1, 1, 32'h604, 0, 1, 1, 32'h704, 32'h33330000, 4'hC, 32'h44444444,  0, 1, 1, 0, 1, 1, 32'h704));
    vecs.push_back(mkv("idle2",        1, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,        4'h0, 32'h0,         0, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mkv("flush_gnt",    1, 1, 32'h800, 1, 0, 0, 32'h0,   32'h0,        4'h0, 32'h0,         1, 0, 0, 0, 0, 0, 32'h800));
    vecs.push_back(mkv("flush_drop",   1, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,        4'h0, 32'h55555555,  0, 0, 0, 0, 0, 1, 32'h0));
    vecs.push_back(mkv("dm_flush",     1, 0, 32'h0,   1, 1, 0, 32'h900, 32'h0,        4'h0, 32'h0,         0, 1, 0, 0, 0, 0, 32'h900));
    vecs.push_back(mkv("dm_flush_rsp", 1, 0, 32'h0,   1, 0, 0, 32'h0,   32'h0,        4'h0, 32'h66666666,  0, 0, 0, 1, 0, 1, 32'h0));
    vecs.push_back(mkv("idle3",        1, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,        4'h0, 32'h0,         0, 0, 0, 0, 0, 0, 32'h0));

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      drive(v.rst_n, v.if_req, v.if_addr, v.flush, v.dm_req, v.dm_wen,
            v.dm_addr, v.wdata, v.mask, v.rdata);
      chk({v.nm, ".if_gnt"},  {31'd0, if_gnt1},  {31'd0, v.e_if_gnt});
      chk({v.nm, ".dm_gnt"},  {31'd0, dm_gnt1},  {31'd0, v.e_dm_gnt});
      chk({v.nm, ".mem_req"}, {31'd0, mem_req1}, {31'd0, v.e_if_gnt | v.e_dm_gnt});
      chk({v.nm, ".mem_wen"}, {31'd0, mem_wen1}, {31'd0, v.e_wen});
      chk({v.nm, ".if_rvld"}, {31'd0, if_rvld1}, {31'd0, v.e_if_rvld});
      chk({v.nm, ".dm_rvld"}, {31'd0, dm_rvld1}, {31'd0, v.e_dm_rvld});
      chk({v.nm, ".busy"},    {31'd0, busy1},    {31'd0, v.e_busy});
      if (v.e_if_gnt || v.e_dm_gnt)
        chk({v.nm, ".mem_addr"}, mem_addr1, v.e_addr);
      if (v.e_wen) begin
        chk({v.nm, ".mem_wdata"}, mem_wdata1, v.wdata);
        chk({v.nm, ".mem_mask"},  {28'd0, mem_mask1}, {28'd0, v.mask});
      end
      if (v.e_if_rvld) chk({v.nm, ".if_rdata"}, if_rdata1, v.rdata);
      if (v.e_dm_rvld) chk({v.nm, ".dm_rdata"}, dm_rdata1, v.rdata);
    end

    // MEM_LAT=2 sequences on u2, starting from a clean reset.
    drive(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);

    // IF read with two-cycle latency.
    drive(1, 1, 32'h100, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    chk2("lat2_T", 1, 0, 0, 0, 0);
    chk("lat2_T.mem_addr", mem_addr2, 32'h100);
    drive(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    chk2("lat2_T1", 0, 0, 0, 0, 1);
    drive(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'hDEADBEEF);
    chk2("lat2_T2", 0, 0, 1, 0, 1);
    chk("lat2_T2.if_rdata", if_rdata2, 32'hDEADBEEF);
    drive(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    chk2("lat2_T3", 0, 0, 0, 0, 0);

    // Flush mid-read drops the IF response; DM waits for the response slot.
    drive(1, 1, 32'h110, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    chk2("fl_T", 1, 0, 0, 0, 0);
    drive(1, 0, 32'h0, 1, 1, 0, 32'h120, 32'h0, 4'h0, 32'h0);
    chk2("fl_T1", 0, 0, 0, 0, 1);
    drive(1, 0, 32'h0, 0, 1, 0, 32'h120, 32'h0, 4'h0, 32'h77777777);
    chk2("fl_T2", 0, 1, 0, 0, 1);
    chk("fl_T2.mem_addr", mem_addr2, 32'h120);
    drive(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    chk2("fl_T3", 0, 0, 0, 0, 1);
    drive(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D);
    chk2("fl_T4", 0, 0, 0, 1, 1);
    chk("fl_T4.dm_rdata", dm_rdata2, 32'hCAFEF00D);

    // Reset during WAIT abandons the read.
    drive(1, 1, 32'h130, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    chk2("rst_T", 1, 0, 0, 0, 0);
    drive(0, 1, 32'h130, 0, 1, 0, 32'h140, 32'h0, 4'h0, 32'h0);
    chk2("rst_T1", 0, 0, 0, 0, 0);
    chk("rst_T1.mem_req", {31'd0, mem_req2}, 32'd0);
    drive(0, 0, 32'h0, 0, 1, 0, 32'h140, 32'h0, 4'h0, 32'h88888888);
    chk2("rst_T2", 0, 0, 0, 0, 0);
    drive(1, 0, 32'h0, 0, 1, 0, 32'h140, 32'h0, 4'h0, 32'h88888888);
    chk2("rst_T3", 0, 1, 0, 0, 0);
    drive(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    chk2("rst_T4", 0, 0, 0, 0, 1);
    drive(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h99999999);
    chk2("rst_T5", 0, 0, 0, 1, 1);
    chk("rst_T5.dm_rdata", dm_rdata2, 32'h99999999);

    // Report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
